// File: rtl/lms_pkg.sv
// Shared types and helpers for the block-LMS coefficient adapter.
// State encoding, derived-width helpers and a signed saturation function.
package lms_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_ADAPT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   function automatic int acc_bw(input int coef_bw, input int acc_ext);
      return coef_bw + acc_ext;
   endfunction

   function automatic int grad_bw(input int in_bw, input int err_bw, input int upd_log2);
      return in_bw + err_bw + upd_log2;
   endfunction

   // Clamp a wide signed value into the range of a w-bit two's complement number.
   function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      return v;
   endfunction

endpackage

// File: rtl/lms_tap_update.sv
// One LMS tap: gradient sum over an update period, scaled step, saturating accumulator.
// Optional leakage term when LMS_LEAKAGE_EN is defined.
module lms_tap_update
   import lms_pkg::*;
#(
   parameter int IN_BW    = 11,
   parameter int ERR_BW   = 9,
   parameter int COEF_BW  = 9,
   parameter int ACC_EXT  = 10,
   parameter int UPD_LOG2 = 2,
   parameter int INIT_VAL = 0
`ifdef LMS_LEAKAGE_EN
   , parameter int LEAK_SHIFT = 12
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      reload,
   input  logic                      accum,
   input  logic                      update,
   input  logic signed [IN_BW-1:0]   x,
   input  logic signed [ERR_BW-1:0]  err,
   input  logic [3:0]                mu_shift,
   output logic signed [COEF_BW-1:0] coef
);

   localparam int ACC_BW  = acc_bw(COEF_BW, ACC_EXT);
   localparam int GRAD_BW = grad_bw(IN_BW, ERR_BW, UPD_LOG2);
   localparam int PROD_BW = IN_BW + ERR_BW;
   localparam logic signed [ACC_BW-1:0] ACC_INIT = ACC_BW'(INIT_VAL * (2 ** ACC_EXT));

   logic signed [ACC_BW-1:0]  acc_reg;
   logic signed [GRAD_BW-1:0] grad_reg;
   logic signed [PROD_BW-1:0] prod;
   logic signed [GRAD_BW-1:0] grad_sum;
   logic signed [GRAD_BW-1:0] step;
   logic signed [63:0]        acc_wide;
   logic signed [ACC_BW-1:0]  acc_next;

   assign prod     = PROD_BW'(err) * PROD_BW'(x);
   // The final sample of the period is folded in directly, so the update needs no extra cycle.
   assign grad_sum = grad_reg + GRAD_BW'(prod);
   assign step     = grad_sum >>> (UPD_LOG2 + int'(mu_shift));

`ifdef LMS_LEAKAGE_EN
   assign acc_wide = 64'(acc_reg) - 64'(acc_reg >>> LEAK_SHIFT) + 64'(step);
`else
   assign acc_wide = 64'(acc_reg) + 64'(step);
`endif

   assign acc_next = ACC_BW'(sat_s(acc_wide, ACC_BW));
   assign coef     = acc_reg[ACC_BW-1:ACC_EXT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grad_reg <= '0;
         acc_reg  <= ACC_INIT;
      end else if (reload) begin
         grad_reg <= '0;
         acc_reg  <= ACC_INIT;
      end else if (update) begin
         grad_reg <= '0;
         acc_reg  <= acc_next;
      end else if (clr) begin
         grad_reg <= '0;
      end else if (accum) begin
         grad_reg <= grad_sum;
      end
   end

endmodule

// File: rtl/lms_coef_adapt.sv
// Block-LMS coefficient writer for the FFE: delay line, control FSM, period counter, bus packing.
// Build option: define LMS_LEAKAGE_EN to add coefficient leakage at each update.
module lms_coef_adapt
   import lms_pkg::*;
#(
   parameter int IN_BW       = 11,
   parameter int ERR_BW      = 9,
   parameter int COEF_BW     = 9,
   parameter int N_COEF      = 7,
   parameter int ACC_EXT     = 10,
   parameter int UPD_LOG2    = 2,
   parameter int ERR_DLY     = 2,
   parameter int CENTER_TAP  = 3,
   parameter int CENTER_INIT = 128,
   parameter int LEAK_SHIFT  = 12
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_en,
   input  logic signed [IN_BW-1:0]     i_data,
   input  logic signed [ERR_BW-1:0]    i_err,
   input  logic [3:0]                  i_mu_shift,
   input  logic                        i_freeze,
   input  logic                        i_reinit,
   output logic [COEF_BW*N_COEF-1:0]   o_coefs,
   output logic                        o_upd,
   output logic [1:0]                  o_state
);

   localparam int DEPTH = ERR_DLY + N_COEF;

   if (CENTER_TAP >= N_COEF || LEAK_SHIFT < 1 || LEAK_SHIFT >= COEF_BW + ACC_EXT) begin : g_param_check
      $error("lms_coef_adapt: CENTER_TAP or LEAK_SHIFT out of range");
   end

   logic signed [IN_BW-1:0] x_reg [DEPTH];
   state_t                  state_reg;
   logic [UPD_LOG2-1:0]     cnt_reg;
   logic                    upd_reg;
   logic                    adapt_en;
   logic                    do_upd;
   logic                    hold;

   assign adapt_en = (state_reg == ST_ADAPT) && i_en && !i_reinit;
   assign do_upd   = adapt_en && (cnt_reg == {UPD_LOG2{1'b1}});
   assign hold     = (state_reg == ST_HOLD);

   // The delay line runs in every state so the taps see valid history when adaptation resumes.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int j = 0; j < DEPTH; j++)
            x_reg[j] <= '0;
      end else if (i_en) begin
         x_reg[0] <= i_data;
         for (int j = 1; j < DEPTH; j++)
            x_reg[j] <= x_reg[j-1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= ST_INIT;
         cnt_reg   <= '0;
         upd_reg   <= 1'b0;
      end else begin
         upd_reg <= do_upd;
         if (i_reinit) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
         end else begin
            case (state_reg)
               ST_INIT: begin
                  state_reg <= ST_ADAPT;
                  cnt_reg   <= '0;
               end
               ST_ADAPT: begin
                  if (i_en)
                     cnt_reg <= cnt_reg + 1'b1;
                  if (i_freeze)
                     state_reg <= ST_HOLD;
               end
               ST_HOLD: begin
                  cnt_reg <= '0;
                  if (!i_freeze)
                     state_reg <= ST_ADAPT;
               end
               default: begin
                  state_reg <= ST_INIT;
                  cnt_reg   <= '0;
               end
            endcase
         end
      end
   end

   for (genvar gi = 0; gi < N_COEF; gi++) begin : g_tap
      lms_tap_update #(
         .IN_BW    (IN_BW),
         .ERR_BW   (ERR_BW),
         .COEF_BW  (COEF_BW),
         .ACC_EXT  (ACC_EXT),
         .UPD_LOG2 (UPD_LOG2),
         .INIT_VAL ((gi == CENTER_TAP) ? CENTER_INIT : 0)
`ifdef LMS_LEAKAGE_EN
         , .LEAK_SHIFT (LEAK_SHIFT)
`endif
      ) u_tap (
         .clk      (i_clk),
         .rst      (i_rst),
         .clr      (hold),
         .reload   (i_reinit),
         .accum    (adapt_en),
         .update   (do_upd),
         .x        (x_reg[ERR_DLY+gi]),
         .err      (i_err),
         .mu_shift (i_mu_shift),
         .coef     (o_coefs[gi*COEF_BW +: COEF_BW])
      );
   end

   assign o_upd   = upd_reg;
   assign o_state = state_reg;

endmodule

// File: tb/tb_lms_coef_adapt.sv
// Self-checking bench for lms_coef_adapt: per-cycle reference model plus directed literal checks.
// Model follows LMS_LEAKAGE_EN the same way the design does.
module tb_lms_coef_adapt;

   localparam int IN_BW       = 11;
   localparam int ERR_BW      = 9;
   localparam int COEF_BW     = 9;
   localparam int N_COEF      = 7;
   localparam int ACC_EXT     = 10;
   localparam int UPD_LOG2    = 2;
   localparam int ERR_DLY     = 2;
   localparam int CENTER_TAP  = 3;
   localparam int CENTER_INIT = 128;
   localparam int LEAK_SHIFT  = 12;
   localparam int ACC_BW      = COEF_BW + ACC_EXT;
   localparam int PERIOD      = 1 << UPD_LOG2;
   localparam int DEPTH       = ERR_DLY + N_COEF;

   logic                          clk;
   logic                          rst;
   logic                          en;
   logic signed [IN_BW-1:0]       data;
   logic signed [ERR_BW-1:0]      err;
   logic [3:0]                    mu;
   logic                          freeze;
   logic                          reinit;
   logic [COEF_BW*N_COEF-1:0]     coefs;
   logic                          upd;
   logic [1:0]                    state;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int upd_cyc[$];

   // reference model state
   longint m_acc [N_COEF];
   longint m_grad [N_COEF];
   int     m_cnt;
   int     m_state;
   logic   m_upd;
   longint hist[$];

   lms_coef_adapt #(
      .IN_BW(IN_BW), .ERR_BW(ERR_BW), .COEF_BW(COEF_BW), .N_COEF(N_COEF),
      .ACC_EXT(ACC_EXT), .UPD_LOG2(UPD_LOG2), .ERR_DLY(ERR_DLY),
      .CENTER_TAP(CENTER_TAP), .CENTER_INIT(CENTER_INIT), .LEAK_SHIFT(LEAK_SHIFT)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_err(err),
      .i_mu_shift(mu), .i_freeze(freeze), .i_reinit(reinit),
      .o_coefs(coefs), .o_upd(upd), .o_state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dut_coef(input int k);
      logic signed [COEF_BW-1:0] c;
      c = coefs[k*COEF_BW +: COEF_BW];
      return int'(c);
   endfunction

   function automatic longint init_acc(input int k);
      return (k == CENTER_TAP) ? longint'(CENTER_INIT) * (longint'(1) << ACC_EXT) : 0;
   endfunction

   function automatic longint sat_acc(input longint v);
      longint hi;
      longint lo;
      hi = (longint'(1) << (ACC_BW - 1)) - 1;
      lo = -(longint'(1) << (ACC_BW - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 60)
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   // Model: plain arithmetic on the sample history, updated once per clock edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state = 0;
         m_cnt   = 0;
         m_upd   = 1'b0;
         hist.delete();
         for (int k = 0; k < N_COEF; k++) begin
            m_acc[k]  = init_acc(k);
            m_grad[k] = 0;
         end
      end else begin
         m_upd = 1'b0;
         if (reinit) begin
            m_state = 0;
            m_cnt   = 0;
            for (int k = 0; k < N_COEF; k++) begin
               m_acc[k]  = init_acc(k);
               m_grad[k] = 0;
            end
         end else if (m_state == 0) begin
            m_state = 1;
         end else if (m_state == 1) begin
            if (en) begin
               for (int k = 0; k < N_COEF; k++) begin
                  longint xk;
                  xk = (hist.size() > ERR_DLY + k) ? hist[ERR_DLY+k] : 0;
                  m_grad[k] += longint'(err) * xk;
               end
               m_cnt++;
               if (m_cnt == PERIOD) begin
                  for (int k = 0; k < N_COEF; k++) begin
                     longint stp;
                     stp = m_grad[k] >>> (UPD_LOG2 + int'(mu));
`ifdef LMS_LEAKAGE_EN
                     m_acc[k] = sat_acc(m_acc[k] - (m_acc[k] >>> LEAK_SHIFT) + stp);
`else
                     m_acc[k] = sat_acc(m_acc[k] + stp);
`endif
                     m_grad[k] = 0;
                  end
                  m_cnt = 0;
                  m_upd = 1'b1;
               end
            end
            if (freeze) m_state = 2;
         end else begin
            m_cnt = 0;
            for (int k = 0; k < N_COEF; k++) m_grad[k] = 0;
            if (!freeze) m_state = 1;
         end
         if (en) begin
            hist.push_front(longint'(data));
            if (hist.size() > DEPTH) void'(hist.pop_back());
         end
      end
   end

   // Compare every cycle, one line per coefficient update.
   always @(negedge clk) begin
      for (int k = 0; k < N_COEF; k++)
         check($sformatf("coef%0d", k), dut_coef(k), int'(m_acc[k] >>> ACC_EXT));
      check("upd", int'(upd), int'(m_upd));
      check("state", int'(state), m_state);
      if (upd === 1'b1) begin
         upd_cyc.push_back(cyc);
         $display("update %0d cycle %0d coefs %0d %0d %0d %0d %0d %0d %0d", upd_cyc.size(), cyc,
                  dut_coef(0), dut_coef(1), dut_coef(2), dut_coef(3), dut_coef(4), dut_coef(5), dut_coef(6));
      end
      cyc++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all(input string name, input int other, input int center);
      for (int k = 0; k < N_COEF; k++)
         check($sformatf("%s_tap%0d", name, k), dut_coef(k), (k == CENTER_TAP) ? center : other);
   endtask

   task automatic check_gap(input string name, input int exp);
      if (upd_cyc.size() >= 2)
         check(name, upd_cyc[upd_cyc.size()-1] - upd_cyc[upd_cyc.size()-2], exp);
      else
         check({name, "_count"}, upd_cyc.size(), 2);
   endtask

   initial begin
      int n_before;
      int edges;
      bit got;

      rst = 1'b1; en = 1'b1; data = 11'sd256; err = 9'sd64; mu = 4'd8;
      freeze = 1'b1; reinit = 1'b0;

      // reset state
      @(negedge clk);
      check_all("reset", 0, 128);
      check("reset_state", int'(state), 0);
      check("reset_upd", int'(upd), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick(1);
      @(negedge clk);
      check("init_to_adapt", int'(state), 1);

      // prefill delay line while frozen, then 16 updates with continuous enable
      tick(12);
      freeze = 1'b0;
      tick(PERIOD * 16 + 1);
      @(negedge clk);
      check_all("cont16", 1, 129);
      check_gap("gap_cont", 4);

      // half-rate enable: 16 more updates
      for (int i = 0; i < 128; i++) begin
         en = (i % 2 == 0);
         tick(1);
      end
      en = 1'b1;
      @(negedge clk);
      check_all("toggle32", 2, 130);
      check_gap("gap_toggle", 8);

      // freeze mid-period
      tick(2);
      n_before = upd_cyc.size();
      freeze = 1'b1;
      tick(10);
      @(negedge clk);
      check("frozen_no_upd", upd_cyc.size(), n_before);
      check_all("frozen", 2, 130);
      @(posedge clk); #1;
      freeze = 1'b0;
      edges = 0;
      got = 1'b0;
      while (!got && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (upd === 1'b1) got = 1'b1;
      end
      check("release_edges", edges, 5);

      // positive then negative saturation
      @(posedge clk); #1;
      err = 9'sd255; data = 11'sd1023; mu = 4'd0;
      tick(40);
      @(negedge clk);
      check_all("sat_pos", 255, 255);
      @(posedge clk); #1;
      err = -9'sd256;
      tick(40);
      @(negedge clk);
      check_all("sat_neg", -256, -256);

      // reinit has priority over freeze
      @(posedge clk); #1;
      reinit = 1'b1; freeze = 1'b1;
      tick(1);
      @(negedge clk);
      check("reinit_state", int'(state), 0);
      check("reinit_upd", int'(upd), 0);
      check_all("reinit", 0, 128);
      @(posedge clk); #1;
      reinit = 1'b0;
      tick(1);
      @(negedge clk);
      check("after_init", int'(state), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("to_hold", int'(state), 2);

      // irregular traffic against the model
      @(posedge clk); #1;
      freeze = 1'b0; mu = 4'd3;
      for (int i = 0; i < 200; i++) begin
         en     = ($urandom_range(0, 3) != 0);
         data   = IN_BW'($urandom_range(0, 2047));
         err    = ERR_BW'($urandom_range(0, 511));
         freeze = ($urandom_range(0, 15) == 0);
         tick(1);
      end
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lms_coef_adapt.md
Name: lms_coef_adapt

Overview:
- Coefficient writer for the feed-forward equalizer. Produces the packed coefficient bus the FFE consumes.
- Adapts coefficients using block LMS: per tap, the product err*x is accumulated over 2^UPD_LOG2 enabled samples, scaled by a power-of-two step size, and added to a saturating high-precision coefficient accumulator.
- Sits beside the FFE. Receives the same input samples plus the slicer error; its output drives the FFE coefficient input directly.

Parameters:
- IN_BW, 11: input sample width, signed.
- ERR_BW, 9: slicer error width, signed.
- COEF_BW, 9: coefficient width, signed S(9,7).
- N_COEF, 7: number of taps.
- ACC_EXT, 10: extra fractional bits in the coefficient accumulator; ACC_BW = COEF_BW+ACC_EXT.
- UPD_LOG2, 2: update period is 2^UPD_LOG2 enabled samples.
- ERR_DLY, 2: enabled-sample delay that aligns data to the error (FFE plus slicer latency).
- CENTER_TAP, 3: index of the tap initialised to CENTER_INIT.
- CENTER_INIT, 128: initial center coefficient (1.0 in S(9,7)); all other taps initialise to 0.
- LEAK_SHIFT, 12: leakage shift; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  sample enable; all sample-rate state advances only when high.
- i_data  in  IN_BW  equalizer input sample, signed.
- i_err  in  ERR_BW  slicer error, signed, aligned ERR_DLY enabled samples after its data.
- i_mu_shift  in  4  step size: right shift applied to the averaged gradient.
- i_freeze  in  1  hold coefficients.
- i_reinit  in  1  synchronous reload of initial coefficients.
- o_coefs  out  COEF_BW*N_COEF  packed bus C(N-1)..C0; C0 is in the LSBs.
- o_upd  out  1  one-cycle pulse on each cycle in which o_coefs changes due to adaptation.
- o_state  out  2  0=INIT, 1=ADAPT, 2=HOLD.

Behaviour:
- Reset (async, i_rst=1):
  - state=INIT; delay line, gradient sums and period counter are cleared.
  - acc[CENTER_TAP]=CENTER_INIT<<ACC_EXT; all other acc=0.
  - o_coefs shows the initial values immediately; o_upd=0.
- Delay line: on i_en, x[0]<=i_data and x[j]<=x[j-1], for a total depth of ERR_DLY+N_COEF. Tap k uses the sample delayed ERR_DLY+k enabled samples relative to the current i_err.
- State machine:
  - INIT lasts one clock, then goes to ADAPT.
  - ADAPT goes to HOLD when i_freeze=1. HOLD returns to ADAPT when i_freeze=0.
  - i_reinit=1 in any state: next state is INIT, acc values are reloaded to their initial values, and grads and counter are cleared. i_reinit has priority over i_freeze.
- Gradient accumulation (ADAPT, i_en=1):
  - prod[k]=i_err*x_k, full precision, IN_BW+ERR_BW bits.
  - grad[k]+=prod[k]; grad width is IN_BW+ERR_BW+UPD_LOG2, so it cannot overflow.
  - The period counter increments each enabled sample.
- Coefficient update, on the enabled sample where the counter reaches 2^UPD_LOG2-1:
  - step[k] = (grad[k]+prod[k]) >>> (UPD_LOG2+i_mu_shift), arithmetic shift.
  - acc[k] = sat_ACC_BW(acc[k]+step[k]).
  - grad and counter clear in the same edge; o_upd=1 for the following cycle.
- Output mapping: o_coefs[k] = acc[k][ACC_BW-1:ACC_EXT] (truncation). Output latency is 1 clock after the last sample of the period.
- Saturation: clamp to +(2^(ACC_BW-1)-1) or -2^(ACC_BW-1). The result never wraps.
- i_en=0: delay line, grads and counter hold; no update occurs.
- HOLD: grads and counter are cleared, acc is held, the delay line keeps shifting, and o_upd=0. A partial period in progress is discarded.
- i_mu_shift is sampled at the update edge only.

Optional Feature:
- LMS_LEAKAGE_EN defined: at each update, acc[k] = sat(acc[k] - (acc[k]>>>LEAK_SHIFT) + step[k]).
  - The center tap also leaks.
  - With zero error, coefficients decay toward 0.
- LMS_LEAKAGE_EN undefined: pure LMS with no leak term and no extra logic.

Decomposition:
- Package lms_pkg holds:
  - state encoding localparams (ST_INIT, ST_ADAPT, ST_HOLD);
  - width helpers for ACC_BW and GRAD_BW;
  - a signed saturate function.
- Sub-module lms_tap_update: one tap's gradient register, accumulator, saturation, leakage and reinit logic. Instantiated N_COEF times via generate. The top level owns the delay line, FSM, counter and bus packing.

Test Plan:
- Reset release with defaults -> o_coefs: tap3=128, others 0; o_state goes INIT then ADAPT after 1 clk; o_upd=0.
- Constant i_data=+256, i_err=+64, i_mu_shift=8, i_en=1 -> each update adds step=64 to acc; o_upd pulses every 4 enabled samples; each tap gains +1 every 16 updates (tap3 reaches 129 at update 16).
- Same stimulus with i_en toggling 1/0 -> update spacing doubles to 8 clocks; coefficient values match the continuous-enable case per update count.
- i_freeze=1 mid-period for 10 clks, then 0 -> no o_upd while frozen and o_coefs unchanged; first update occurs 4 enabled samples after release.
- i_err=+255, i_data=+1023, i_mu_shift=0 for many periods -> every tap saturates at +255, with no wrap to negative. Then i_reinit=1 and i_freeze=1 together -> initial coefficients are restored, and the next state is INIT, not HOLD.
- With LMS_LEAKAGE_EN defined, i_err=0, LEAK_SHIFT=2 -> tap3 decays 128 -> 96 -> 72 on successive updates (within truncation).
